codec_cfg_sequencer: RTL and testbench
======================================

// Module: codec_cfg_sequencer
// PURPOSE
//  Owns the single i2cgenerator write port to the audio codec at 7'h1a.
//  After reset it replays a fixed codec init table, one 16-bit word per write.
//  Each word is {reg_addr[7:0], value[7:0]}.
//  It then arbitrates runtime write requests from two requesters with a
//  round-robin scheme and serialises them onto the generator's load/ready handshake.
//  It replaces ad-hoc per-key FSMs in top-levels such as the loopback/silence controls.
// PARAMETERS
//  INIT_LEN      6    number of init table entries (indices 0..INIT_LEN-1)
//  BUSY_TIMEOUT  8    cycles to wait for ready to fall after load before flagging err
// PORTS
//  clk          in   1   system clock (CLOCK_50)
//  reset        in   1   synchronous, active-low reset (0 at posedge = reset)
//  gen_ready    in   1   i2cgenerator ready
//  gen_load     out  1   one-cycle load strobe to i2cgenerator
//  gen_data     out  16  word to i2cgenerator; held stable from load until next load
//  req          in   2   write requests; req[i] held high until ack[i]
//  req_data0    in   16  word for requester 0, sampled on grant
//  req_data1    in   16  word for requester 1, sampled on grant
//  ack          out  2   one-cycle pulse when requester i's write completes
//  reinit       in   1   pulse: replay init table (accepted only in IDLE)
//  init_done    out  1   high once the whole init table has been written
//  busy         out  1   high whenever a write is in flight or init is running
//  err          out  1   sticky: some write never saw ready fall within BUSY_TIMEOUT
// BEHAVIOUR
//  Reset values (reset==0 at posedge)
//   - all outputs 0: gen_load=0, gen_data=16'h0000, ack=2'b00, init_done=0, busy=0, err=0
//   - internal: state=INIT, idx=0, rr_ptr=0 (requester 0 has priority)
//  Init table, in order:
//   0F00 (codec reset), 0C00 (power up), 0E02 (I2S 16b), 1000 (normal 48k),
//   0402 (analog path silence), 1201 (active)
//  All outputs are registered.
//  States:
//   - INIT: busy=1. When gen_ready=1: next cycle gen_load=1, gen_data=table[idx] -> BUSY.
//   - IDLE: busy=0.
//       - reinit=1 (priority over req): idx=0, init_done=0 -> INIT.
//       - else if gen_ready=1 and req!=0: grant one requester -> ISSUE.
//         If both request, grant rr_ptr; otherwise grant the sole requester.
//       - ISSUE: latch req_dataN; next cycle gen_load=1, gen_data=that word -> BUSY.
//   - BUSY: gen_load back to 0.
//       - Wait for gen_ready==0 -> DONE.
//       - If gen_ready is still 1 after BUSY_TIMEOUT cycles: err<=1 -> DONE.
//   - DONE: wait for gen_ready==1.
//       - Init write, idx<INIT_LEN-1: idx++ -> INIT.
//       - Init write, last entry: init_done<=1 -> IDLE.
//       - Request write: ack[g]=1 for one cycle, rr_ptr<=~g -> IDLE.
//  Handshake and boundary rules
//   - gen_load is never asserted while gen_ready=0; never two loads without ready fall+rise.
//   - Requests arriving during INIT wait; none is granted before init_done=1.
//   - req dropped before grant: ignored. Dropped after grant: the write still
//     completes and ack still pulses.
//   - reinit outside IDLE: ignored (not queued).
//   - reset mid-transfer: immediate return to reset values.
//       - No ack for the aborted write.
//       - Init restarts at entry 0 after release.
//   - err clears only on reset.
//   - Minimum latency from grant (IDLE, ready=1) to gen_load: 2 cycles.
// TESTING
//  Bench model: generator drops ready 1 cycle after load and stays low 20 cycles.
//  1 Release reset -> exactly 6 loads: 0F00,0C00,0E02,1000,0402,1201.
//    init_done rises after the 6th ready return; err=0.
//  2 req[0]=1, req_data0=040A at cycle 3 -> no load until after init_done.
//    Then one load of 040A and one ack[0] pulse.
//  3 After init, req=11 held (data0=040A, data1=0402) -> loads 040A, then 0402.
//    ack[0] pulses, then ack[1]. Re-raise both -> 040A is granted first.
//  4 Model holds ready=1 permanently -> err=1 about 8 cycles after the first load.
//    All 6 loads still issue; init_done=1.
//  5 Assert reset during BUSY of entry 2 -> next cycle gen_load=0, gen_data=0, init_done=0.
//    After release, the sequence restarts at 0F00.
//  6 reinit pulse in IDLE -> init_done=0 and 6-load replay.
//    A reinit pulse during that replay is ignored; no extra loads.

Source files
------------

// File: rtl/codec_cfg_sequencer_if.sv
// Write-port bundle between codec_cfg_sequencer, the i2cgenerator and the
// two runtime requesters.
//
// Signals
//   gen_ready  generator -> sequencer  generator idle, may accept a load
//   gen_load   sequencer -> generator  one-cycle load strobe
//   gen_data   sequencer -> generator  {reg_addr, value}, stable from load to next load
//   req[1:0]   requester -> sequencer  write request, held high until ack
//   req_data0  requester -> sequencer  word for requester 0, sampled on grant
//   req_data1  requester -> sequencer  word for requester 1, sampled on grant
//   ack[1:0]   sequencer -> requester  one-cycle pulse when that write completes
//
// Handshake: gen_load pulses for one cycle only while gen_ready=1; the
// generator then drops gen_ready while it works and raises it again when
// finished, and only then may the next load happen. req[i] is a level held
// until ack[i] pulses; a request dropped before grant is simply forgotten,
// one dropped after grant still completes and still gets its ack.
interface codec_cfg_sequencer_if;
  logic        gen_ready;
  logic        gen_load;
  logic [15:0] gen_data;
  logic [1:0]  req;
  logic [15:0] req_data0;
  logic [15:0] req_data1;
  logic [1:0]  ack;

  modport master (
    input  gen_ready, req, req_data0, req_data1,
    output gen_load, gen_data, ack
  );

  modport slave (
    output gen_ready, req, req_data0, req_data1,
    input  gen_load, gen_data, ack
  );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: sole owner of the i2cgenerator write port to the
// audio codec. After reset it replays a fixed init table (one {reg,value}
// word per write), then serves runtime writes from two requesters with
// round-robin arbitration.
//
// Ports
//   clk        system clock (CLOCK_50)
//   reset      synchronous active-low reset
//   bus        codec_cfg_sequencer_if.master (generator + requester handshakes)
//   reinit     pulse: replay init table, honoured only in IDLE
//   init_done  high once the whole init table has been written
//   busy       high while init runs or a write is in flight
//   err        sticky: a load never saw gen_ready fall within BUSY_TIMEOUT cycles
//   state_dbg  current FSM state, for observation
module codec_cfg_sequencer #(
  parameter int INIT_LEN     = 6,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  codec_cfg_sequencer_if.master bus,
  input  logic                  reinit,
  output logic                  init_done,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               rr_ptr;
  logic               gnt;
  logic [15:0]        req_word;
  logic               grant_sel;

  function automatic logic [15:0] init_word(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       init_word = 16'h0F00; // codec reset
      1:       init_word = 16'h0C00; // power up
      2:       init_word = 16'h0E02; // I2S, 16 bit
      3:       init_word = 16'h1000; // normal mode, 48k
      4:       init_word = 16'h0402; // analog path silence
      5:       init_word = 16'h1201; // active
      default: init_word = 16'h0000;
    endcase
  endfunction

  // With both requesting, rr_ptr picks; otherwise the lone requester wins.
  assign grant_sel = (bus.req == 2'b11) ? rr_ptr : bus.req[1];
  assign state_dbg = state;

  // Init writes happen only while init_done=0 and request writes only while
  // init_done=1, so init_done alone tells DONE which kind of write finished.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_INIT;
      idx          <= '0;
      tmo_cnt      <= '0;
      rr_ptr       <= 1'b0;
      gnt          <= 1'b0;
      req_word     <= 16'h0000;
      bus.gen_load <= 1'b0;
      bus.gen_data <= 16'h0000;
      bus.ack      <= 2'b00;
      init_done    <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.gen_load <= 1'b0;
      bus.ack      <= 2'b00;
      case (state)
        ST_INIT: begin
          busy <= 1'b1;
          if (bus.gen_ready) begin
            bus.gen_load <= 1'b1;
            bus.gen_data <= init_word(idx);
            tmo_cnt      <= '0;
            state        <= ST_BUSY;
          end
        end
        ST_IDLE: begin
          busy <= 1'b0;
          if (reinit) begin
            idx       <= '0;
            init_done <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_INIT;
          end else if (bus.gen_ready && (bus.req != 2'b00)) begin
            gnt      <= grant_sel;
            req_word <= grant_sel ? bus.req_data1 : bus.req_data0;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.gen_ready) begin
            bus.gen_load <= 1'b1;
            bus.gen_data <= req_word;
            tmo_cnt      <= '0;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Counts from the cycle the load is visible.
          if (!bus.gen_ready) begin
            state <= ST_DONE;
          end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.gen_ready) begin
            if (!init_done) begin
              if (idx == IDX_W'(INIT_LEN - 1)) begin
                init_done <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= ST_INIT;
              end
            end else begin
              bus.ack <= gnt ? 2'b10 : 2'b01;
              rr_ptr  <= ~gnt;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Self-checking bench for codec_cfg_sequencer. A generator model drops
// gen_ready one cycle after each load and holds it low for 20 cycles (or
// holds it high permanently in the timeout scenario). Expected loads
// ({init_done, gen_data}) and acks are queued when stimulus is driven and
// popped when the DUT produces them.
module tb_codec_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       reinit;
  logic       init_done;
  logic       busy;
  logic       err;
  logic [2:0] state_dbg;

  codec_cfg_sequencer_if bif ();

  codec_cfg_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .reinit    (reinit),
    .init_done (init_done),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Generator model.
  logic perm_ready;
  int   gen_cnt;
  always @(posedge clk) begin
    if (!reset) begin
      bif.gen_ready <= 1'b1;
      gen_cnt       <= 0;
    end else if (perm_ready) begin
      bif.gen_ready <= 1'b1;
      gen_cnt       <= 0;
    end else if (bif.gen_load) begin
      bif.gen_ready <= 1'b0;
      gen_cnt       <= 20;
    end else if (gen_cnt > 0) begin
      gen_cnt <= gen_cnt - 1;
      if (gen_cnt == 1) bif.gen_ready <= 1'b1;
    end
  end

  // Scoreboard state.
  logic [16:0] exp_q[$];
  logic [1:0]  exp_ack_q[$];
  int          total;
  int          bad;
  int          load_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 16'h0F00});
    exp_q.push_back({1'b0, 16'h0C00});
    exp_q.push_back({1'b0, 16'h0E02});
    exp_q.push_back({1'b0, 16'h1000});
    exp_q.push_back({1'b0, 16'h0402});
    exp_q.push_back({1'b0, 16'h1201});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (init_done && !busy && exp_q.size() == 0 && exp_ack_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_loads(input string tag, input int target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (load_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    bif.req = 2'b00;
    reinit  = 1'b0;
    step(2);
    exp_q.delete();
    exp_ack_q.delete();
    reset = 1'b1;
  endtask

  int base;

  initial begin
    total         = 0;
    bad           = 0;
    load_cnt      = 0;
    perm_ready    = 1'b0;
    reset         = 1'b0;
    reinit        = 1'b0;
    bif.req       = 2'b00;
    bif.req_data0 = 16'h0000;
    bif.req_data1 = 16'h0000;

    // Monitor: scoreboard pops on every load and every ack; requesters
    // drop their request when they see their ack.
    fork
      forever begin
        @(negedge clk);
        if (reset && bif.gen_load) begin
          load_cnt++;
          chk("load_while_ready", 32'(bif.gen_ready), 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_load", 32'(bif.gen_data), 32'hFFFF_FFFF);
          end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            chk("load_word", {15'd0, init_done, bif.gen_data}, {15'd0, e});
          end
        end
        if (reset && bif.ack != 2'b00) begin
          if (exp_ack_q.size() == 0) begin
            chk("unexpected_ack", 32'(bif.ack), 32'd0);
          end else begin
            chk("ack_order", 32'(bif.ack), 32'(exp_ack_q.pop_front()));
          end
          bif.req = bif.req & ~bif.ack;
        end
      end
    join_none

    // Reset values.
    step(3);
    chk("rst_gen_load", 32'(bif.gen_load), 32'd0);
    chk("rst_gen_data", 32'(bif.gen_data), 32'h0000);
    chk("rst_ack", 32'(bif.ack), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Init replay, with requester 0 asking during init.
    push_init();
    exp_q.push_back({1'b1, 16'h040A});
    exp_ack_q.push_back(2'b01);
    reset = 1'b1;
    step(3);
    bif.req_data0 = 16'h040A;
    bif.req       = 2'b01;
    wait_idle("init_then_req0", 1500);
    chk("init_err", 32'(err), 32'd0);
    chk("init_done_high", 32'(init_done), 32'd1);

    // Round robin from a fresh reset.
    do_reset();
    push_init();
    wait_idle("rr_init", 1500);
    bif.req_data0 = 16'h040A;
    bif.req_data1 = 16'h0402;
    exp_q.push_back({1'b1, 16'h040A});
    exp_q.push_back({1'b1, 16'h0402});
    exp_ack_q.push_back(2'b01);
    exp_ack_q.push_back(2'b10);
    bif.req = 2'b11;
    wait_idle("rr_pair1", 500);
    exp_q.push_back({1'b1, 16'h040A});
    exp_q.push_back({1'b1, 16'h0402});
    exp_ack_q.push_back(2'b01);
    exp_ack_q.push_back(2'b10);
    bif.req = 2'b11;
    wait_idle("rr_pair2", 500);
    chk("rr_err", 32'(err), 32'd0);

    // Reset during BUSY of entry 2.
    do_reset();
    push_init();
    base = load_cnt;
    wait_loads("mid_wait", base + 3, 500);
    reset = 1'b0;
    step(1);
    chk("mid_gen_load", 32'(bif.gen_load), 32'd0);
    chk("mid_gen_data", 32'(bif.gen_data), 32'h0000);
    chk("mid_init_done", 32'(init_done), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    step(1);
    push_init();
    reset = 1'b1;
    wait_idle("mid_restart", 1500);

    // reinit in IDLE replays; reinit during the replay is ignored.
    push_init();
    base   = load_cnt;
    reinit = 1'b1;
    step(1);
    reinit = 1'b0;
    step(1);
    chk("reinit_clears_done", 32'(init_done), 32'd0);
    wait_loads("reinit_wait", base + 2, 500);
    reinit = 1'b1;
    step(1);
    reinit = 1'b0;
    wait_idle("reinit_replay", 1500);
    step(80);
    chk("reinit_load_count", 32'(load_cnt - base), 32'd6);
    chk("reinit_done", 32'(init_done), 32'd1);

    // Generator never drops ready: timeout flags err, init still completes.
    perm_ready = 1'b1;
    do_reset();
    push_init();
    base = load_cnt;
    wait_loads("tmo_first", base + 1, 100);
    step(6);
    chk("tmo_err_early", 32'(err), 32'd0);
    step(2);
    chk("tmo_err_set", 32'(err), 32'd1);
    wait_idle("tmo_all_loads", 1500);
    chk("tmo_load_count", 32'(load_cnt - base), 32'd6);
    chk("tmo_init_done", 32'(init_done), 32'd1);
    chk("tmo_err_sticky", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
